fb_scanout: RTL and testbench

FB_SCANOUT -- requirements
Module: fb_scanout

---
 rtl/fb_pkg.sv | 60 ++++++
 rtl/vga_timing_gen.sv | 58 +++++
 rtl/fb_scanout.sv | 159 +++++++++++++++
 tb/tb_fb_scanout.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared 640x480@60 raster constants, types and helpers for the framebuffer
// read (scan-out) and write-address paths.
package fb_pkg;

  // Horizontal timing in pixel clocks
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int H_TOTAL      = H_SYNC_END + H_BP;      // 800

  // Vertical timing in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int V_TOTAL      = V_SYNC_END + V_BP;      // 525

  localparam int H_CNT_W   = 10;
  localparam int V_CNT_W   = 10;
  localparam int FB_ADDR_W = 19;
  localparam int COLOR_W   = 6;

  // Test-pattern bars are 80 pixels wide, eight across the active line
  localparam int BAR_W = 80;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_t;

  // Video control bits travelling down the output pipeline
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};

  // Bar number x/80 by comparison, since 80 is not a power of two
  function automatic logic [2:0] bar_index(input logic [H_CNT_W-1:0] x);
    logic [2:0] idx;
    idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (x >= H_CNT_W'(i * BAR_W)) idx = 3'(i);
    end
    return idx;
  endfunction

  // Each bar-index bit drives both bits of one colour channel
  function automatic logic [COLOR_W-1:0] bar_colour(input logic [2:0] b);
    return {b[2], b[2], b[1], b[1], b[0], b[0]};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster position counters with raw (un-pipelined) sync and active flags.
// Counters advance only while i_advance is high and sit at 0,0 otherwise.
module vga_timing_gen
  import fb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_advance,
  output logic [H_CNT_W-1:0] o_h_cnt,
  output logic [V_CNT_W-1:0] o_v_cnt,
  output logic               o_h_active,
  output logic               o_v_active,
  output logic               o_hsync_n,
  output logic               o_vsync_n,
  output logic               o_h_wrap,
  output logic               o_frame_end
);

  localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_ACT    = H_CNT_W'(H_ACTIVE);
  localparam logic [V_CNT_W-1:0] V_ACT    = V_CNT_W'(V_ACTIVE);
  localparam logic [H_CNT_W-1:0] H_SYNC_S = H_CNT_W'(H_SYNC_START);
  localparam logic [H_CNT_W-1:0] H_SYNC_E = H_CNT_W'(H_SYNC_END);
  localparam logic [V_CNT_W-1:0] V_SYNC_S = V_CNT_W'(V_SYNC_START);
  localparam logic [V_CNT_W-1:0] V_SYNC_E = V_CNT_W'(V_SYNC_END);

  logic [H_CNT_W-1:0] r_h_cnt;
  logic [V_CNT_W-1:0] r_v_cnt;

  // Raster counters: h every clock, v on h wrap, both parked at 0 when idle
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!i_advance) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_h_cnt     = r_h_cnt;
  assign o_v_cnt     = r_v_cnt;
  assign o_h_active  = (r_h_cnt < H_ACT);
  assign o_v_active  = (r_v_cnt < V_ACT);
  assign o_hsync_n   = !((r_h_cnt >= H_SYNC_S) && (r_h_cnt < H_SYNC_E));
  assign o_vsync_n   = !((r_v_cnt >= V_SYNC_S) && (r_v_cnt < V_SYNC_E));
  assign o_h_wrap    = (r_h_cnt == H_LAST);
  assign o_frame_end = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out for 640x480: run/idle control, multiplier-free read
// addressing and a 2-stage output pipeline aligning sync with pixel data.
// Optional build macro FB_SCANOUT_TEST_PATTERN_EN adds a test_mode input
// that replaces framebuffer colour with eight vertical colour bars.
module fb_scanout
  import fb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
`ifdef FB_SCANOUT_TEST_PATTERN_EN
  input  logic                 test_mode,
`endif
  output logic                 fb_rd_en,
  output logic [FB_ADDR_W-1:0] fb_rd_addr,
  input  logic [COLOR_W-1:0]   fb_rd_data,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [COLOR_W-1:0]   rgb_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [FB_ADDR_W-1:0] LINE_STEP = FB_ADDR_W'(H_ACTIVE);
  localparam logic [V_CNT_W-1:0]   V_LAST_ACT = V_CNT_W'(V_ACTIVE - 1);

  scan_state_t          r_state;
  logic                 r_busy;
  logic [H_CNT_W-1:0]   w_h_cnt;
  logic [V_CNT_W-1:0]   w_v_cnt;
  logic                 w_h_active;
  logic                 w_v_active;
  logic                 w_hsync_n;
  logic                 w_vsync_n;
  logic                 w_h_wrap;
  logic                 w_frame_end;
  logic                 w_running;
  logic                 w_visible;
  logic                 w_rd_en;
  logic [FB_ADDR_W-1:0] r_line_base;
  logic [FB_ADDR_W-1:0] r_addr_hold;
  logic [FB_ADDR_W-1:0] w_addr;
  sync_t                r_s1;
  sync_t                r_s2;
  logic [COLOR_W-1:0]   r_rgb;
  logic [COLOR_W-1:0]   w_colour;

  assign w_running = (r_state == ST_RUN);

  vga_timing_gen u_timing (
    .clk         (clk),
    .rst         (rst),
    .i_advance   (w_running),
    .o_h_cnt     (w_h_cnt),
    .o_v_cnt     (w_v_cnt),
    .o_h_active  (w_h_active),
    .o_v_active  (w_v_active),
    .o_hsync_n   (w_hsync_n),
    .o_vsync_n   (w_vsync_n),
    .o_h_wrap    (w_h_wrap),
    .o_frame_end (w_frame_end)
  );

  // Run control: start on enable, stop only at the last pixel of a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (enable) begin
          r_state <= ST_RUN;
          r_busy  <= 1'b1;
        end
        ST_RUN: if (w_frame_end && !enable) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign frame_done = w_running & w_frame_end;
  assign w_visible  = w_running & w_h_active & w_v_active;

  // Line base steps by one line width per visible line, reset at frame wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line_base <= '0;
    end else if (!w_running || (w_h_wrap && w_frame_end)) begin
      r_line_base <= '0;
    end else if (w_h_wrap && (w_v_cnt < V_LAST_ACT)) begin
      r_line_base <= r_line_base + LINE_STEP;
    end
  end

  assign w_addr     = r_line_base + FB_ADDR_W'(w_h_cnt);
  // Outside visible pixels the last issued address is held
  assign fb_rd_addr = w_rd_en ? w_addr : r_addr_hold;
  assign fb_rd_en   = w_rd_en;

  // Remember the last address so it can be held during blanking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_addr_hold <= '0;
    else     r_addr_hold <= fb_rd_addr;
  end

`ifdef FB_SCANOUT_TEST_PATTERN_EN
  logic       r_pat1;
  logic [2:0] r_bar1;

  assign w_rd_en = w_visible & ~test_mode;

  // Carry the pattern select and bar number alongside the memory read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat1 <= 1'b0;
      r_bar1 <= '0;
    end else begin
      r_pat1 <= test_mode;
      r_bar1 <= bar_index(w_h_cnt);
    end
  end

  assign w_colour = r_pat1 ? bar_colour(r_bar1) : fb_rd_data;
`else
  assign w_rd_en  = w_visible;
  assign w_colour = fb_rd_data;
`endif

  // Stage 1: control bits wait while the framebuffer returns data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_s1 <= SYNC_IDLE;
    else     r_s1 <= '{hsync: w_hsync_n, vsync: w_vsync_n, de: w_visible};
  end

  // Stage 2: register sync with the pixel colour, blanking outside de
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2  <= SYNC_IDLE;
      r_rgb <= '0;
    end else begin
      r_s2  <= r_s1;
      r_rgb <= r_s1.de ? w_colour : '0;
    end
  end

  assign hsync   = r_s2.hsync;
  assign vsync   = r_s2.vsync;
  assign de      = r_s2.de;
  assign rgb_out = r_rgb;

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: a position-based raster model predicts
// every output each cycle, plus directed checks on timing and control corners.
module tb_fb_scanout;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fb_rd_en;
  logic [18:0] fb_rd_addr;
  logic [5:0]  fb_rd_data;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [5:0]  rgb_out;
  logic        busy;
  logic        frame_done;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
  logic        test_mode;
`endif

  fb_scanout dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    .test_mode  (test_mode),
`endif
    .fb_rd_en   (fb_rd_en),
    .fb_rd_addr (fb_rd_addr),
    .fb_rd_data (fb_rd_data),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .rgb_out    (rgb_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Framebuffer model: word at address a holds a[5:0]; junk when not read
  always @(posedge clk)
    fb_rd_data <= fb_rd_en ? fb_rd_addr[5:0] : 6'($urandom);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [5:0] rgb;
  } out_t;

  localparam out_t OUT_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 6'd0};

  bit   m_run;
  int   m_pos;         // cycles into the current frame, 0..419999
  int   m_last_addr;
  bit   tm;
  out_t d1, d2;        // what the outputs show 1 and 2 cycles later

  function automatic logic [5:0] bar_rgb(input int x);
    int b;
    b = x / 80;
    return 6'(((b >> 2) & 1) * 48 + ((b >> 1) & 1) * 12 + (b & 1) * 3);
  endfunction

  // Expected stage-0 behaviour for a frame position
  function automatic void stage0(input bit run, input int pos, input bit tmode,
                                 output bit en, output int addr, output out_t o,
                                 output bit fdone);
    int x, y;
    bit vis;
    x     = pos % 800;
    y     = pos / 800;
    vis   = run && x < 640 && y < 480;
    en    = vis && !tmode;
    addr  = x + 640 * y;
    o.hs  = !(run && x >= 656 && x < 752);
    o.vs  = !(run && y >= 490 && y < 492);
    o.de  = vis;
    o.rgb = !vis ? 6'd0 : (tmode ? bar_rgb(x) : 6'(addr % 64));
    fdone = run && pos == 419999;
  endfunction

  // Measurement state
  int cyc = 0;
  int mm_cnt = 0;
  bit mm_reported = 0;
  bit prev_hs, prev_vs;
  int hs_fall_at, vs_fall_at;
  int hs_period = 0, hs_low = 0, vs_period = 0, vs_low = 0;
  int rd_cnt, frame_rd = 0, max_addr, fd_count = 0;

  task automatic reset_model();
    m_run = 0; m_pos = 0; m_last_addr = 0;
    d1 = OUT_IDLE; d2 = OUT_IDLE;
    prev_hs = 1; prev_vs = 1;
    hs_fall_at = -1; vs_fall_at = -1;
    rd_cnt = 0; max_addr = 0;
  endtask

  task automatic note(input string name, input logic [31:0] obs, input logic [31:0] exp);
    if (obs !== exp) begin
      mm_cnt++;
      if (!mm_reported) begin
        mm_reported = 1;
        $display("first divergence at cycle %0d on %s: got %0d want %0d", cyc, name, obs, exp);
      end
    end
  endtask

  // One clock: advance model at the rising edge, compare at the falling edge
  task automatic tick();
    bit en, fd;
    int a;
    out_t o;
    @(posedge clk);
    stage0(m_run, m_pos, tm, en, a, o, fd);
    if (en) m_last_addr = a;
    d2 = d1;
    d1 = o;
    if (rst) begin
      m_run = 0; m_pos = 0;
    end else if (m_run) begin
      if (m_pos == 419999) begin
        m_pos = 0;
        m_run = enable;
      end else m_pos++;
    end else if (enable) begin
      m_run = 1; m_pos = 0;
    end
    @(negedge clk);
    cyc++;
    stage0(m_run, m_pos, tm, en, a, o, fd);
    note("fb_rd_en",   fb_rd_en,   en);
    note("fb_rd_addr", fb_rd_addr, en ? a : m_last_addr);
    note("busy",       busy,       m_run);
    note("frame_done", frame_done, fd);
    note("hsync",      hsync,      d2.hs);
    note("vsync",      vsync,      d2.vs);
    note("de",         de,         d2.de);
    note("rgb_out",    rgb_out,    d2.rgb);
    if (prev_hs === 1'b1 && hsync === 1'b0) begin
      if (hs_fall_at >= 0) hs_period = cyc - hs_fall_at;
      hs_fall_at = cyc;
    end
    if (prev_hs === 1'b0 && hsync === 1'b1 && hs_fall_at >= 0) hs_low = cyc - hs_fall_at;
    if (prev_vs === 1'b1 && vsync === 1'b0) begin
      if (vs_fall_at >= 0) vs_period = cyc - vs_fall_at;
      vs_fall_at = cyc;
    end
    if (prev_vs === 1'b0 && vsync === 1'b1 && vs_fall_at >= 0) vs_low = cyc - vs_fall_at;
    prev_hs = hsync;
    prev_vs = vsync;
    if (fb_rd_en === 1'b1) begin
      rd_cnt++;
      if (int'(fb_rd_addr) > max_addr) max_addr = int'(fb_rd_addr);
    end
    if (frame_done === 1'b1) begin
      fd_count++;
      frame_rd = rd_cnt;
      rd_cnt   = 0;
    end
  endtask

  task automatic wait_pos(input int target, input int budget, input string tag);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      hit = m_run && m_pos == target;
    end
    check(tag, hit, 1);
  endtask

  task automatic wait_addr(input int target, input int budget, input string tag);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      hit = fb_rd_en === 1'b1 && fb_rd_addr === 19'(target);
    end
    check(tag, hit, 1);
  endtask

  task automatic wait_fd(input int budget, input string tag);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      hit = frame_done === 1'b1;
    end
    check(tag, hit, 1);
  endtask

  initial begin
    rst = 1; enable = 0; tm = 0;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    test_mode = 0;
`endif
    reset_model();
    repeat (4) tick();
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_de", de, 0);
    check("rst_rgb", rgb_out, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", fb_rd_en, 0);
    check("rst_addr", fb_rd_addr, 0);
    check("rst_frame_done", frame_done, 0);

    rst = 0;
    repeat (3) tick();
    check("idle_busy", busy, 0);
    check("idle_rd_en", fb_rd_en, 0);

    // First run: addressing near the top of the frame
    enable = 1;
    tick();
    check("start_rd_en", fb_rd_en, 1);
    check("start_addr", fb_rd_addr, 0);
    check("start_busy", busy, 1);
    wait_addr(5, 20, "reach_addr5");
    tick();
    tick();
    check("rgb_x5", rgb_out, 5);
    check("de_x5", de, 1);
    wait_pos(800, 2000, "reach_y1");
    check("addr_x0_y1", fb_rd_addr, 640);

    // Mid-frame reset at x=300, y=200
    wait_pos(200 * 800 + 300, 200000, "reach_x300_y200");
    check("addr_x300_y200", fb_rd_addr, 128300);
    rst = 1;
    reset_model();
    #1;
    check("abort_hsync", hsync, 1);
    check("abort_vsync", vsync, 1);
    check("abort_de", de, 0);
    check("abort_rd_en", fb_rd_en, 0);
    enable = 0;
    repeat (2) tick();
    rst = 0;
    repeat (2) tick();
    check("post_rst_busy", busy, 0);
    enable = 1;
    tick();
    check("restart_rd_en", fb_rd_en, 1);
    check("restart_addr", fb_rd_addr, 0);
    check("model_reset_phase", mm_cnt, 0);
    mm_cnt = 0;

    // Frame A: full frame with enable held
    wait_addr(307199, 420000, "reach_last_addr");
    tick();
    tick();
    check("rgb_last", rgb_out, 63);
    fd_count = 0;
    wait_fd(40000, "frame_a_done");
    check("frame_a_rd_count", frame_rd, 307200);
    check("max_addr", max_addr, 307199);
    check("hsync_period", hs_period, 800);
    check("hsync_low", hs_low, 96);
    check("vsync_low", vs_low, 1600);
    check("busy_at_done", busy, 1);
    tick();
    check("no_gap_rd_en", fb_rd_en, 1);
    check("no_gap_addr", fb_rd_addr, 0);
    check("no_gap_busy", busy, 1);
    check("model_frame_a", mm_cnt, 0);
    mm_cnt = 0;

    // Frame B: drop enable at y=100, frame must still complete
    wait_pos(100 * 800, 90000, "reach_y100");
    enable = 0;
    fd_count = 0;
    wait_fd(420000, "frame_b_done");
    check("frame_b_rd_count", frame_rd, 307200);
    check("vsync_period", vs_period, 420000);
    tick();
    check("busy_after_stop", busy, 0);
    rd_cnt = 0;
    repeat (1000) tick();
    check("rd_en_after_stop", rd_cnt, 0);
    check("frame_done_pulses", fd_count, 1);
    check("idle_hsync", hsync, 1);
    check("idle_vsync", vsync, 1);
    check("idle_de", de, 0);
    check("idle_rgb", rgb_out, 0);
    check("model_frame_b", mm_cnt, 0);
    mm_cnt = 0;

`ifdef FB_SCANOUT_TEST_PATTERN_EN
    begin
      int bad_lo = 0, bad_hi = 0, x;
      test_mode = 1; tm = 1; enable = 1;
      rd_cnt = 0;
      for (int k = 0; k < 700; k++) begin
        tick();
        x = m_pos - 2;
        if (x >= 0 && x < 80 && rgb_out !== 6'b000000) bad_lo++;
        if (x >= 560 && x < 640 && rgb_out !== 6'b111111) bad_hi++;
      end
      check("tp_bar0_pixels", bad_lo, 0);
      check("tp_bar7_pixels", bad_hi, 0);
      check("tp_rd_en", rd_cnt, 0);
      check("model_pattern", mm_cnt, 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
